// File: rtl/serial_mag_cmp_if.sv
// serial_mag_cmp_if -- request/result bundle for the bit-serial comparator.
//   start        : request a compare (only honoured while the comparator is idle)
//   op_a, op_b   : unsigned operands, captured on the accepting edge
//   busy         : shifting is underway past the first bit pair
//   done         : one-cycle pulse, eq/gt/lt valid
//   eq, gt, lt   : registered compare result, held until the next done
// master = requester side, slave = comparator side.
interface serial_mag_cmp_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             busy;
  logic             done;
  logic             eq;
  logic             gt;
  logic             lt;

  modport master (output start, op_a, op_b,
                  input  busy, done, eq, gt, lt);
  modport slave  (input  start, op_a, op_b,
                  output busy, done, eq, gt, lt);
endinterface

// File: rtl/serial_mag_cmp.sv
// serial_mag_cmp -- bit-serial unsigned magnitude comparator.
// Operands are captured on an accepted start and walked MSB-first, one bit
// pair per clock, through a single registered equal/greater slice (e, g).
// The edge that consumes the last pair writes eq/gt/lt and enters DONE,
// so done is high for the cycle after edge k+WIDTH (k = accepting edge).
//
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous, active-high reset
//   bus  : serial_mag_cmp_if.slave (start, op_a, op_b / busy, done, eq, gt, lt)
//
// Build option: define EARLY_EXIT_EN to leave SHIFT on the first edge where
// the operands are resolved (first differing bit); results are unchanged.
module serial_mag_cmp #(
  parameter int WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  serial_mag_cmp_if.slave bus
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, nxt;
  logic [WIDTH-1:0] sa, sb;
  logic [CW-1:0]    cnt;
  logic             e, g;
  logic             eq_r, gt_r, lt_r;
  logic             busy_r;

  // slice update for the current MSB pair
  logic a_bit, b_bit, e_nx, g_nx;
  assign a_bit = sa[WIDTH-1];
  assign b_bit = sb[WIDTH-1];
  assign e_nx  = e & ~(a_bit ^ b_bit);
  assign g_nx  = g | (e & a_bit & ~b_bit);

  always_comb begin
    nxt = state;
    case (state)
      IDLE:  if (bus.start) nxt = SHIFT;
`ifdef EARLY_EXIT_EN
      SHIFT: if (cnt == '0 || !e_nx) nxt = DONE;
`else
      SHIFT: if (cnt == '0) nxt = DONE;
`endif
      DONE:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      sa     <= '0;
      sb     <= '0;
      cnt    <= '0;
      e      <= 1'b0;
      g      <= 1'b0;
      eq_r   <= 1'b0;
      gt_r   <= 1'b0;
      lt_r   <= 1'b0;
      busy_r <= 1'b0;
    end else begin
      state  <= nxt;
      // busy covers the shift cycles after the first one: it is high only
      // when a shift edge leaves us still shifting, i.e. WIDTH-1 cycles for
      // a full compare. Registered so the output never glitches.
      busy_r <= (state == SHIFT) && (nxt == SHIFT);
      case (state)
        IDLE: begin
          if (bus.start) begin
            sa  <= bus.op_a;
            sb  <= bus.op_b;
            e   <= 1'b1;
            g   <= 1'b0;
            cnt <= CW'(WIDTH - 1);
          end
        end
        SHIFT: begin
          e   <= e_nx;
          g   <= g_nx;
          sa  <= {sa[WIDTH-2:0], 1'b0};
          sb  <= {sb[WIDTH-2:0], 1'b0};
          cnt <= cnt - CW'(1);
          if (nxt == DONE) begin
            eq_r <= e_nx;
            gt_r <= g_nx;
            lt_r <= ~e_nx & ~g_nx;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = (state == DONE);
  assign bus.eq   = eq_r;
  assign bus.gt   = gt_r;
  assign bus.lt   = lt_r;
endmodule

// File: tb/tb_serial_mag_cmp.sv
module tb_serial_mag_cmp;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_bad = 0;
  int   n_done = 0;
  int   exp_done = 0;
  int   busy_cnt = 0;
  logic [2:0] last_res = 3'b000;

  typedef struct {
    logic [2:0] res;   // {eq,gt,lt}
    int         due;   // posedge count after which done must be seen
    int         bsy;   // busy cycles expected for this compare
  } exp_t;
  exp_t sb_q[$];

  serial_mag_cmp_if #(.WIDTH(W)) bus ();
  serial_mag_cmp #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h @cyc %0d", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [2:0] model_res(input logic [W-1:0] a, input logic [W-1:0] b);
    if (a == b) return 3'b100;
    if (a > b)  return 3'b010;
    return 3'b001;
  endfunction

  function automatic int model_lat(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef EARLY_EXIT_EN
    for (int i = W - 1; i >= 0; i--)
      if (a[i] != b[i]) return W - i;
`endif
    return W;
  endfunction

  function automatic exp_t mk(input logic [W-1:0] a, input logic [W-1:0] b, input int acc);
    exp_t x;
    x.res = model_res(a, b);
    x.due = acc + model_lat(a, b);
    x.bsy = model_lat(a, b) - 1;
    return x;
  endfunction

  // monitor: pop the scoreboard on each done, check result, timing, busy
  // span and that results hold between pulses
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        n_done++;
        if (sb_q.size() == 0) chk("spurious_done", 32'd1, 32'd0);
        else begin
          exp_t x;
          x = sb_q.pop_front();
          chk("result",  {29'd0, bus.eq, bus.gt, bus.lt}, {29'd0, x.res});
          chk("latency", cyc, x.due);
          chk("busy_span", busy_cnt, x.bsy);
          chk("onehot", $countones({bus.eq, bus.gt, bus.lt}), 32'd1);
          last_res = {bus.eq, bus.gt, bus.lt};
        end
        busy_cnt = 0;
      end else begin
        chk("hold", {29'd0, bus.eq, bus.gt, bus.lt}, {29'd0, last_res});
      end
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op_a  = a;
    bus.op_b  = b;
    sb_q.push_back(mk(a, b, cyc + 1));
    exp_done++;
    @(negedge clk);
    bus.start = 1'b0;
    bus.op_a  = W'($urandom);   // post-accept operand changes must not matter
    bus.op_b  = W'($urandom);
  endtask

  task automatic drain();
    int k = 0;
    while (sb_q.size() != 0 && k < 60) begin
      @(negedge clk); #1;
      k++;
    end
    if (sb_q.size() != 0) begin
      chk("timeout", sb_q.size(), 32'd0);
      sb_q.delete();
    end
  endtask

  task automatic run(input logic [W-1:0] a, input logic [W-1:0] b);
    issue(a, b);
    drain();
  endtask

  logic [W-1:0] va [6] = '{8'hA5, 8'h01, 8'h7F, 8'h80, 8'h00, 8'hFF};
  logic [W-1:0] vb [6] = '{8'hA5, 8'h00, 8'h80, 8'h7F, 8'h01, 8'hFE};

  initial begin
    bus.start = 1'b0;
    bus.op_a  = '0;
    bus.op_b  = '0;
    #12;
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_res",  {29'd0, bus.eq, bus.gt, bus.lt}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run(va[i], vb[i]);
    for (int i = 0; i < 6; i++) run(W'($urandom), W'($urandom_range(0, 3) == 0 ? 0 : $urandom));

    // ignored start mid-SHIFT: no second compare, no queued request
    issue(8'h10, 8'h20);
    repeat (2) @(negedge clk);
    bus.start = 1'b1; bus.op_a = 8'hFF; bus.op_b = 8'h00;
    @(negedge clk);
    bus.start = 1'b0;
    drain();
    repeat (15) @(negedge clk);

    // back-to-back with start held: accepts spaced by WIDTH shifts + DONE + IDLE
    begin
      int acc1;
      @(negedge clk);
      bus.start = 1'b1; bus.op_a = 8'h03; bus.op_b = 8'h03;
      acc1 = cyc + 1;
      sb_q.push_back(mk(8'h03, 8'h03, acc1));
      sb_q.push_back(mk(8'hF0, 8'h0F, acc1 + W + 2));
      exp_done += 2;
      @(negedge clk);
      bus.op_a = 8'hF0; bus.op_b = 8'h0F;
      while (cyc < acc1 + W + 2 && cyc < acc1 + 40) @(negedge clk);
      bus.start = 1'b0;
      drain();
    end

    // async reset mid-SHIFT: everything drops at once, no done follows
    run(8'hFF, 8'h00);   // leave a nonzero result to see it cleared
    issue(8'h5A, 8'h3C);
    repeat (2) @(negedge clk);
    chk("busy_pre_rst", bus.busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("rst_busy_mid", bus.busy, 1'b0);
    chk("rst_done_mid", bus.done, 1'b0);
    chk("rst_res_mid",  {29'd0, bus.eq, bus.gt, bus.lt}, 32'd0);
    sb_q.delete();
    exp_done--;
    busy_cnt = 0;
    last_res = 3'b000;
    @(negedge clk);
    rst = 1'b0;
    repeat (15) @(negedge clk);

    run(8'h3C, 8'h5A);
    repeat (2) @(negedge clk);
    chk("done_count", n_done, exp_done);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
